mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
//
// PURPOSE
// Shares one single-ported, 64-bit-wide unified memory between the core's instruction-fetch
// port and its load/store port. Sits between processor_top and the memory model in the
// simulation top. Data side has priority; a streak counter bounds fetch starvation.
// Registers response routing for a fixed 1-cycle memory read latency.
//
// PARAMETERS
// MAX_D_STREAK  4   consecutive D grants allowed while I is requesting before I is forced a grant
// CNT_W         32  width of the saturating per-port grant counters
//
// PORTS
// clk          in   1      clock, rising edge
// rst_n        in   1      reset, synchronous, active-low
// i_req        in   1      fetch request; held with i_addr stable until granted
// i_addr       in   64     fetch byte address (bits [1:0] ignored)
// i_gnt        out  1      fetch accepted this cycle (combinational)
// i_rvalid     out  1      fetch data valid
// i_rdata      out  32     fetched instruction word
// d_req        in   1      load/store request; held stable until granted
// d_addr       in   64     data byte address (bits [2:0] ignored)
// d_wen        in   1      1 = store, 0 = load
// d_wdata      in   64     store data
// d_byte_en    in   8      store byte enables
// d_gnt        out  1      data request accepted this cycle (combinational)
// d_rvalid     out  1      load data valid / store acknowledge
// d_rdata      out  64     load data
// mem_req      out  1      memory access this cycle
// mem_addr     out  64     doubleword-aligned address {addr[63:3],3'b0}
// mem_wen      out  1      memory write strobe
// mem_wdata    out  64     memory write data
// mem_byte_en  out  8      memory byte enables (8'h00 on reads)
// mem_rdata    in   64     read data, valid 1 cycle after mem_req
// i_gnt_count  out  CNT_W  saturating count of I grants
// d_gnt_count  out  CNT_W  saturating count of D grants
//
// BEHAVIOUR
// - Reset (rst_n low at posedge): i_rvalid, d_rvalid, streak counter, owner register, both
//   grant counters -> 0. i_gnt/d_gnt/mem_req are 0 while rst_n is low.
// - Arbitration (combinational, same cycle): only D requesting -> D; only I -> I;
//   both -> D unless streak == MAX_D_STREAK, then I. Exactly one grant per cycle, at most.
// - Streak: +1 on a D grant while i_req high; cleared on any I grant or cycle with i_req low;
//   never exceeds MAX_D_STREAK.
// - Accepted request drives mem_* that same cycle; store data/enables only when D store granted.
// - Owner register (OWN_NONE/OWN_I/OWN_D) plus latched i_addr[2] captured on grant.
// - Next cycle: OWN_I -> i_rvalid=1, i_rdata = addr2 ? mem_rdata[63:32] : mem_rdata[31:0];
//   OWN_D -> d_rvalid=1, d_rdata = mem_rdata (also pulsed for stores as ack, data don't-care).
// - Throughput: one access per cycle; back-to-back grants legal, responses never overlap.
// - Grant counters increment per grant, saturate at all-ones (no wrap).
// - Reset mid-operation: in-flight response is dropped; no rvalid in the cycle after reset.
// - rdata outputs are 0 when the matching rvalid is 0.
//
// STRUCTURE
// - riscv_pkg: enum arb_owner_e {OWN_NONE, OWN_I, OWN_D}; struct mem_req_t
//   {addr, wen, wdata, byte_en}; constant MEM_RD_LATENCY = 1.
// - Single module; no sub-module needed (counters inline as always_ff blocks).
//
// TESTING
// 1. Reset held 5 cycles with i_req=d_req=1 -> no grants, no mem_req, all outputs 0.
// 2. I only, i_addr=0x104, mem_rdata=0xAAAA_BBBB_CCCC_DDDD -> i_gnt same cycle,
//    next cycle i_rvalid=1, i_rdata=0xAAAABBBB; mem_addr=0x100.
// 3. D store addr=0x20, wdata=0x1122334455667788, byte_en=0x0F -> mem_wen=1, byte_en=0x0F,
//    d_rvalid=1 next cycle; i_gnt_count unchanged, d_gnt_count=1.
// 4. I and D both held high 12 cycles -> grant pattern D,D,D,D,I repeating (MAX_D_STREAK=4);
//    no cycle with two grants, streak never >4.
// 5. Grant to D, rst_n low next posedge -> d_rvalid stays 0; after release, fresh I request
//    granted normally.
// 6. Force d_gnt_count to all-ones (CNT_W=4 override), one more D grant -> stays 4'hF.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_port_arbiter_pkg;

  // Which port owns the response returning from memory in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_I    = 2'd1,
    OWN_D    = 2'd2
  } arb_owner_e;

  typedef struct packed {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  byte_en;
  } mem_req_t;

  localparam int unsigned MEM_RD_LATENCY = 1;

  // Memory is doubleword-wide; drop the byte offset.
  function automatic logic [63:0] dw_align(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported 64-bit memory between fetch (I) and load/store (D).
// D has priority; a streak counter forces an I grant after MAX_D_STREAK back-to-back D grants.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_D_STREAK = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_req,
  input  logic [63:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  input  logic             d_req,
  input  logic [63:0]      d_addr,
  input  logic             d_wen,
  input  logic [63:0]      d_wdata,
  input  logic [7:0]       d_byte_en,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [63:0]      d_rdata,
  output logic             mem_req,
  output logic [63:0]      mem_addr,
  output logic             mem_wen,
  output logic [63:0]      mem_wdata,
  output logic [7:0]       mem_byte_en,
  input  logic [63:0]      mem_rdata,
  output logic [CNT_W-1:0] i_gnt_count,
  output logic [CNT_W-1:0] d_gnt_count
);

  localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

  logic [STREAK_W-1:0] streak_q;
  arb_owner_e          owner_q;
  logic                addr2_q;
  logic [CNT_W-1:0]    i_cnt_q, d_cnt_q;
  mem_req_t            req;

  // Byte-offset bits are architecturally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[1:0], d_addr[2:0]};

  // Same-cycle grant: D wins unless it has starved a waiting fetch for MAX_D_STREAK grants.
  always_comb begin
    d_gnt = 1'b0;
    i_gnt = 1'b0;
    if (rst_n) begin
      d_gnt = d_req && !(i_req && (streak_q == STREAK_MAX));
      i_gnt = i_req && !d_gnt;
    end
  end

  // Drive the memory with whichever request was accepted; write fields only for a D store.
  always_comb begin
    req = '0;
    if (d_gnt) begin
      req.addr = dw_align(d_addr);
      if (d_wen) begin
        req.wen     = 1'b1;
        req.wdata   = d_wdata;
        req.byte_en = d_byte_en;
      end
    end else if (i_gnt) begin
      req.addr = dw_align(i_addr);
    end
  end

  assign mem_req     = i_gnt | d_gnt;
  assign mem_addr    = req.addr;
  assign mem_wen     = req.wen;
  assign mem_wdata   = req.wdata;
  assign mem_byte_en = req.byte_en;

  // Count D grants that bypassed a waiting fetch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (i_gnt || !i_req) begin
      streak_q <= '0;
    end else if (d_gnt && (streak_q != STREAK_MAX)) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  // Remember who owns the response arriving MEM_RD_LATENCY cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= OWN_NONE;
      addr2_q <= 1'b0;
    end else begin
      owner_q <= i_gnt ? OWN_I : (d_gnt ? OWN_D : OWN_NONE);
      if (i_gnt) addr2_q <= i_addr[2];
    end
  end

  assign i_rvalid = (owner_q == OWN_I);
  assign d_rvalid = (owner_q == OWN_D);
  assign i_rdata  = !i_rvalid ? '0 : (addr2_q ? mem_rdata[63:32] : mem_rdata[31:0]);
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  // Saturating grant counter for the fetch port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i_cnt_q <= '0;
    end else if (i_gnt && (i_cnt_q != '1)) begin
      i_cnt_q <= i_cnt_q + 1'b1;
    end
  end

  // Saturating grant counter for the data port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_cnt_q <= '0;
    end else if (d_gnt && (d_cnt_q != '1)) begin
      d_cnt_q <= d_cnt_q + 1'b1;
    end
  end

  assign i_gnt_count = i_cnt_q;
  assign d_gnt_count = d_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized phase
// checked against a cycle-level reference model.
module tb_mem_port_arbiter;

  logic        clk, rst_n;
  logic        i_req, d_req, d_wen;
  logic [63:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [7:0]  d_byte_en;

  logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_req, mem_wen;
  logic [31:0] i_rdata;
  logic [63:0] d_rdata, mem_addr, mem_wdata;
  logic [7:0]  mem_byte_en;
  logic [31:0] i_gnt_count, d_gnt_count;

  logic        s_i_gnt, s_i_rvalid, s_d_gnt, s_d_rvalid, s_mem_req, s_mem_wen;
  logic [31:0] s_i_rdata;
  logic [63:0] s_d_rdata, s_mem_addr, s_mem_wdata;
  logic [7:0]  s_mem_byte_en;
  logic [3:0]  s_i_gnt_count, s_d_gnt_count;

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wdata(mem_wdata),
    .mem_byte_en(mem_byte_en), .mem_rdata(mem_rdata),
    .i_gnt_count(i_gnt_count), .d_gnt_count(d_gnt_count)
  );

  // Narrow-counter instance sharing the same stimulus, for saturation.
  mem_port_arbiter #(.MAX_D_STREAK(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(s_i_gnt), .i_rvalid(s_i_rvalid),
    .i_rdata(s_i_rdata),
    .d_req(d_req), .d_addr(d_addr), .d_wen(d_wen), .d_wdata(d_wdata), .d_byte_en(d_byte_en),
    .d_gnt(s_d_gnt), .d_rvalid(s_d_rvalid), .d_rdata(s_d_rdata),
    .mem_req(s_mem_req), .mem_addr(s_mem_addr), .mem_wen(s_mem_wen), .mem_wdata(s_mem_wdata),
    .mem_byte_en(s_mem_byte_en), .mem_rdata(mem_rdata),
    .i_gnt_count(s_i_gnt_count), .d_gnt_count(s_d_gnt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: pending response port (0 none, 1 I, 2 D), fetch half select,
  // run of D grants taken while I waited, and grant totals.
  int          m_pend;
  bit          m_addr2;
  int          m_streak;
  longint      m_icnt, m_dcnt;
  bit          e_i, e_d;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint sat(input longint v, input longint lim);
    return (v > lim) ? lim : v;
  endfunction

  // Compare every DUT output against the model for the current (settled) cycle.
  task automatic check_now();
    logic [31:0] exp_ir;
    e_d = rst_n && d_req && !(i_req && m_streak == 4);
    e_i = rst_n && i_req && !e_d;
    chk("i_gnt", i_gnt, e_i);
    chk("d_gnt", d_gnt, e_d);
    chk("mem_req", mem_req, e_i | e_d);
    chk("mem_wen", mem_wen, e_d && d_wen);
    if (e_i || e_d) begin
      chk("mem_addr", mem_addr, (e_d ? d_addr : i_addr) & ~64'h7);
      chk("mem_byte_en", mem_byte_en, (e_d && d_wen) ? d_byte_en : 8'h00);
    end
    if (e_d && d_wen) chk("mem_wdata", mem_wdata, d_wdata);
    exp_ir = (m_pend != 1) ? 32'h0 : (m_addr2 ? mem_rdata[63:32] : mem_rdata[31:0]);
    chk("i_rvalid", i_rvalid, m_pend == 1);
    chk("i_rdata", i_rdata, exp_ir);
    chk("d_rvalid", d_rvalid, m_pend == 2);
    chk("d_rdata", d_rdata, (m_pend == 2) ? mem_rdata : 64'h0);
    chk("i_gnt_count", i_gnt_count, sat(m_icnt, 64'hFFFF_FFFF));
    chk("d_gnt_count", d_gnt_count, sat(m_dcnt, 64'hFFFF_FFFF));
    chk("sat_i_gnt_count", s_i_gnt_count, sat(m_icnt, 15));
    chk("sat_d_gnt_count", s_d_gnt_count, sat(m_dcnt, 15));
    chk("sat_i_rdata", s_i_rdata, exp_ir);
  endtask

  // Advance the model using the values sampled at the coming edge, then cross it.
  task automatic advance();
    if (!rst_n) begin
      m_pend = 0; m_addr2 = 0; m_streak = 0; m_icnt = 0; m_dcnt = 0;
    end else begin
      m_pend = e_i ? 1 : (e_d ? 2 : 0);
      if (e_i) m_addr2 = i_addr[2];
      if (e_i || !i_req) m_streak = 0;
      else if (e_d) m_streak++;
      if (e_i) m_icnt++;
      if (e_d) m_dcnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    #1;
    check_now();
    advance();
  endtask

  initial begin
    bit i_held, d_held;
    rst_n = 0; i_req = 0; d_req = 0; d_wen = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_byte_en = 0; mem_rdata = 0;
    m_pend = 0; m_addr2 = 0; m_streak = 0; m_icnt = 0; m_dcnt = 0;
    @(posedge clk); #1;

    // 1. Reset with both ports requesting.
    i_req = 1; d_req = 1; i_addr = 64'h40; d_addr = 64'h80;
    for (int k = 0; k < 5; k++) step();
    chk("reset_no_mem_req", mem_req, 1'b0);
    rst_n = 1; i_req = 0; d_req = 0;
    step();

    // 2. Fetch only, upper word.
    i_req = 1; i_addr = 64'h104;
    #1; check_now();
    chk("t2_i_gnt", i_gnt, 1'b1);
    chk("t2_mem_addr", mem_addr, 64'h100);
    advance();
    i_req = 0; mem_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    #1; check_now();
    chk("t2_i_rvalid", i_rvalid, 1'b1);
    chk("t2_i_rdata", i_rdata, 32'hAAAABBBB);
    advance();

    // 3. Data store.
    d_req = 1; d_wen = 1; d_addr = 64'h20; d_wdata = 64'h1122334455667788; d_byte_en = 8'h0F;
    #1; check_now();
    chk("t3_mem_wen", mem_wen, 1'b1);
    chk("t3_byte_en", mem_byte_en, 8'h0F);
    chk("t3_wdata", mem_wdata, 64'h1122334455667788);
    advance();
    d_req = 0; d_wen = 0;
    #1; check_now();
    chk("t3_d_rvalid", d_rvalid, 1'b1);
    chk("t3_i_cnt", i_gnt_count, 32'd1);
    chk("t3_d_cnt", d_gnt_count, 32'd1);
    advance();

    // 4. Both ports held: D,D,D,D,I repeating.
    i_req = 1; d_req = 1; i_addr = 64'h300; d_addr = 64'h400;
    for (int k = 0; k < 12; k++) begin
      #1; check_now();
      chk("t4_d_pattern", d_gnt, (k % 5) != 4);
      chk("t4_i_pattern", i_gnt, (k % 5) == 4);
      chk("t4_one_grant", i_gnt & d_gnt, 1'b0);
      advance();
    end

    // Randomized traffic honouring hold-until-granted.
    i_held = 0; d_held = 0;
    i_req = 0; d_req = 0;
    for (int k = 0; k < 400; k++) begin
      if (!i_held) begin
        i_req = ($urandom_range(0, 2) != 0);
        i_addr = {$urandom, $urandom};
      end
      if (!d_held) begin
        d_req = ($urandom_range(0, 2) != 0);
        d_addr = {$urandom, $urandom};
        d_wen = $urandom_range(0, 1);
        d_wdata = {$urandom, $urandom};
        d_byte_en = 8'($urandom);
      end
      mem_rdata = {$urandom, $urandom};
      #1; check_now();
      i_held = i_req && !e_i;
      d_held = d_req && !e_d;
      advance();
    end
    i_req = 0; d_req = 0;
    step();

    // 5. Reset lands right after a D grant: its response is dropped.
    d_req = 1; d_wen = 0; d_addr = 64'h88;
    #1; check_now();
    chk("t5_d_gnt", d_gnt, 1'b1);
    rst_n = 0;
    advance();
    d_req = 0;
    #1; check_now();
    chk("t5_no_d_rvalid", d_rvalid, 1'b0);
    advance();
    rst_n = 1; i_req = 1; i_addr = 64'h208; mem_rdata = 64'h0123_4567_89AB_CDEF;
    #1; check_now();
    chk("t5_i_gnt", i_gnt, 1'b1);
    advance();
    i_req = 0;
    #1; check_now();
    chk("t5_i_rdata", i_rdata, 32'h89ABCDEF);
    advance();

    // 6. Narrow counter saturates at all-ones.
    d_req = 1; d_wen = 0;
    for (int k = 0; k < 15; k++) step();
    chk("t6_sat_reached", s_d_gnt_count, 4'hF);
    step();
    chk("t6_sat_hold", s_d_gnt_count, 4'hF);
    chk("t6_wide_cnt", d_gnt_count, 32'd16);
    d_req = 0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
